// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
//   Sequencing controller for the serial pattern detector path. Parallel words
//   are accepted over a valid/ready handshake and serialized MSB-first, one bit
//   per clock. A programmable PAT_W-bit pattern is detected on the continuous
//   bit stream with overlap allowed. Matches are counted with saturation, and an
//   optional sticky threshold interrupt can be raised.
//
//   Optional feature macro: SEQ_CTRL_IRQ_EN
//     defined   : thresh register and sticky irq are present.
//     undefined : irq is tied low; cfg_thresh and irq_clr are ignored.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   cfg_we       in   config write strobe
//   cfg_pattern  in   pattern value, latched on an accepted cfg_we
//   cfg_thresh   in   irq threshold, latched on an accepted cfg_we
//   cfg_err      out  1-cycle pulse: cfg_we ignored because busy or word accept
//   word_valid   in   source has a word
//   word_data    in   word to serialize, MSB first
//   word_ready   out  controller can accept a word this cycle
//   busy         out  controller is shifting a word
//   match        out  registered 1-cycle pulse per pattern completion
//   match_cnt    out  saturating match count
//   irq          out  sticky threshold interrupt
//   irq_clr      in   clears irq
// ---------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int unsigned       WORD_W  = 8,
  parameter int unsigned       PAT_W   = 5,
  parameter logic [PAT_W-1:0]  PAT_RST = 5'b10110,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  output logic              cfg_err,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int unsigned       IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  sreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-1:0]   hist;
  logic [PAT_W-1:0]   pattern;
  logic [FILL_W-1:0]  fill;

  logic               accept;
  logic               consume;
  logic               last_bit;
  logic [PAT_W-1:0]   hist_next;
  logic [FILL_W-1:0]  fill_next;
  logic               hit;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_plus;
  logic               cfg_ok;

  // Ready in IDLE, or on the last bit of the current word so a new word can be
  // loaded on the same edge that consumes that bit (gap-free streaming).
  assign word_ready = !rst && ((state == IDLE) || (bit_idx == LAST_IDX));
  assign accept     = word_valid && word_ready;
  assign consume    = (state == SHIFT);
  assign last_bit   = consume && (bit_idx == LAST_IDX);

  assign hist_next  = {hist[PAT_W-2:0], sreg[WORD_W-1]};
  assign fill_next  = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign hit        = consume && (hist_next == pattern) && (fill_next >= FILL_MAX);
  assign cnt_inc    = hit && (match_cnt != CNT_MAX);
  assign cnt_plus   = match_cnt + 1'b1;

  // A config write is only honoured while idle with no word being taken.
  assign cfg_ok     = cfg_we && (state == IDLE) && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_idx   <= '0;
      hist      <= '0;
      fill      <= '0;
      pattern   <= PAT_RST;
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_we && !cfg_ok;

      if (consume) begin
        hist    <= hist_next;
        fill    <= fill_next;
        sreg    <= {sreg[WORD_W-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end

      if (cnt_inc) begin
        match_cnt <= cnt_plus;
      end

      // Word loads come after the consume update so a load on the last-bit
      // edge overrides the shift of the finished word.
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= word_data;
            bit_idx <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              sreg    <= word_data;
              bit_idx <= '0;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Only possible in IDLE, where nothing is consumed, so no conflict with
      // the history/counter updates above.
      if (cfg_ok) begin
        pattern   <= cfg_pattern;
        hist      <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end
    end
  end

`ifdef SEQ_CTRL_IRQ_EN
  logic [CNT_W-1:0] thresh;
  logic             irq_set;

  // Set only on a real increment reaching the threshold; saturated holds
  // leave the counter unchanged and therefore cannot set irq again.
  assign irq_set = cnt_inc && (thresh != '0) && (cnt_plus == thresh);

  always_ff @(posedge clk) begin
    if (rst) begin
      thresh <= '0;
      irq    <= 1'b0;
    end else begin
      if (cfg_ok) begin
        thresh <= cfg_thresh;
      end
      if (irq_set) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{cfg_thresh, irq_clr};
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl
//   Self-checking bench for seq_det_ctrl. The reference model keeps a queue of
//   not-yet-consumed bits and a queue of the most recent consumed bits; the
//   controller is idle exactly when no bits are pending.
// ---------------------------------------------------------------------------
module tb_seq_det_ctrl;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned PAT_W   = 5;
  localparam logic [PAT_W-1:0] PAT_RST = 5'b10110;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              cfg_err;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              busy;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic              irq;
  logic              irq_clr;

  seq_det_ctrl #(
    .WORD_W  (WORD_W),
    .PAT_W   (PAT_W),
    .PAT_RST (PAT_RST),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_thresh  (cfg_thresh),
    .cfg_err     (cfg_err),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit               pend[$];   // bits accepted but not yet consumed
  bit               hq[$];     // last consumed bits since reset/config, oldest first
  logic [PAT_W-1:0] m_pat  = PAT_RST;
  int               m_thr  = 0;
  int               m_cnt  = 0;
  logic             m_match = 1'b0;
  logic             m_err  = 1'b0;
  logic             m_irq  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PAT_W-1:0] recent_bits();
    logic [PAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < hq.size(); i++) v = {v[PAT_W-2:0], hq[i]};
    return v;
  endfunction

  // One clock cycle: drive inputs, check ready, advance the model, check outputs.
  task automatic step(input logic v, input logic [WORD_W-1:0] d, input logic we,
                      input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] th,
                      input logic clr, input logic r);
    logic exp_ready;
    logic acc;
    logic idle;
    logic set;
    bit   b;
    word_valid  = v;
    word_data   = d;
    cfg_we      = we;
    cfg_pattern = p;
    cfg_thresh  = th;
    irq_clr     = clr;
    rst         = r;
    exp_ready   = !r && (pend.size() <= 1);
    #1;
    check("word_ready", 32'(word_ready), 32'(exp_ready));
    acc  = v && exp_ready;
    idle = (pend.size() == 0);
    set  = 1'b0;
    if (r) begin
      pend.delete();
      hq.delete();
      m_pat   = PAT_RST;
      m_thr   = 0;
      m_cnt   = 0;
      m_match = 1'b0;
      m_err   = 1'b0;
      m_irq   = 1'b0;
    end else begin
      m_match = 1'b0;
      if (!idle) begin
        b = pend.pop_front();
        hq.push_back(b);
        if (hq.size() > PAT_W) void'(hq.pop_front());
        if (hq.size() == PAT_W && recent_bits() == m_pat) begin
          m_match = 1'b1;
          if (m_cnt < CNT_MAX) begin
            m_cnt++;
            if (m_thr != 0 && m_cnt == m_thr) set = 1'b1;
          end
        end
      end
`ifdef SEQ_CTRL_IRQ_EN
      if (set) m_irq = 1'b1;
      else if (clr) m_irq = 1'b0;
`endif
      if (acc) for (int k = WORD_W - 1; k >= 0; k--) pend.push_back(d[k]);
      m_err = we && !(idle && !acc);
      if (we && idle && !acc) begin
        m_pat = p;
        m_thr = int'(th);
        m_cnt = 0;
        hq.delete();
      end
    end
    @(posedge clk);
    #1;
    check("match",     32'(match),     32'(m_match));
    check("match_cnt", 32'(match_cnt), m_cnt);
    check("busy",      32'(busy),      32'(pend.size() != 0));
    check("cfg_err",   32'(cfg_err),   32'(m_err));
    check("irq",       32'(irq),       32'(m_irq));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [WORD_W-1:0] d);
    step(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic configure(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] th);
    step(1'b0, '0, 1'b1, p, th, 1'b0, 1'b0);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'hA5, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset held with word_valid high
    reset_cycles(3);
    check("rst_cnt", 32'(match_cnt), 0);
    idle_cycles(1);

    // Overlapping matches within one word
    send(8'b1011_0110);
    idle_cycles(9);
    check("ovl_cnt", 32'(match_cnt), 2);

    // Back-to-back words, match spans the boundary
    reset_cycles(1);
    send(8'h0B);
    for (int i = 0; i < 8; i++) send(8'h00);
    idle_cycles(10);
    check("xword_cnt", 32'(match_cnt), 1);

    // Config while shifting is rejected; config in idle applies
    send(8'h3C);
    configure(5'b11111, 8'd0);
    idle_cycles(8);
    configure(5'b11111, 8'd3);
    check("cfg_clr_cnt", 32'(match_cnt), 0);
    send(8'hFF);
    idle_cycles(9);
    check("cfg_ff_cnt", 32'(match_cnt), 4);
`ifdef SEQ_CTRL_IRQ_EN
    check("irq_thr", 32'(irq), 1);
`endif
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);

    // irq_clr held while the threshold is reached: set wins
    configure(5'b11111, 8'd3);
    step(1'b1, 8'hFF, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Saturation with threshold at all-ones
    configure(5'b11111, 8'hFF);
    for (int i = 0; i < 34 * 8; i++) send(8'hFF);
    idle_cycles(9);
    check("sat_cnt", 32'(match_cnt), CNT_MAX);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    send(8'hFF);
    idle_cycles(9);
    check("sat_hold", 32'(match_cnt), CNT_MAX);

    // Reset in the middle of a word
    send(8'hAA);
    idle_cycles(3);
    reset_cycles(1);
    check("midrst_busy", 32'(busy), 0);
    idle_cycles(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7,
           ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'hB6,
           $urandom_range(0, 29) == 0,
           ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'b10110,
           8'($urandom_range(1, 12)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
